// File: rtl/matrix_transpose_ctrl_pkg.sv
// Shared sizes, FSM encoding and element-select helper for the 5x5 transpose controller.
package matrix_transpose_ctrl_pkg;

    localparam int unsigned N     = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned ELEMS = N * N;
    localparam int unsigned AW    = 8;
    localparam int unsigned FW    = ELEMS * DW;
    localparam int unsigned CW    = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Select element idx from a flattened 25-element matrix.
    function automatic logic [DW-1:0] elem_at(input logic [FW-1:0] flat, input logic [CW-1:0] idx);
        logic [DW-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < ELEMS; k++) begin
            if (idx == CW'(k)) v = flat[k*DW +: DW];
        end
        return v;
    endfunction

endpackage

// File: rtl/matrix_transpose_ctrl_if.sv
// Element memory port: one read channel with 1-cycle latency and one write channel.
interface matrix_transpose_ctrl_if;
    import matrix_transpose_ctrl_pkg::*;

    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    modport master (
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/matrix_transpose_ctrl.sv
// Streams a 5x5 byte matrix from memory into an external transpose datapath
// and writes the transposed result back, one element per cycle.
module matrix_transpose_ctrl
    import matrix_transpose_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           src_base,
    input  logic [AW-1:0]           dst_base,
    output logic                    busy,
    output logic                    done,
    output logic [FW-1:0]           a_flat,
    input  logic [FW-1:0]           c_flat,
    matrix_transpose_ctrl_if.master mem
);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [FW-1:0] result;

    logic          rd_en_d, wr_en_d, done_d;
    logic [AW-1:0] rd_addr_d, wr_addr_d;
    logic [DW-1:0] wr_data_d;
    logic          result_en, cap_en;
    logic [CW-1:0] cap_idx;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            src_q           <= '0;
            dst_q           <= '0;
            result          <= '0;
            a_flat          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem.mem_rd_en   <= 1'b0;
            mem.mem_rd_addr <= '0;
            mem.mem_wr_en   <= 1'b0;
            mem.mem_wr_addr <= '0;
            mem.mem_wr_data <= '0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            busy            <= (state_d != IDLE);
            done            <= done_d;
            mem.mem_rd_en   <= rd_en_d;
            mem.mem_rd_addr <= rd_addr_d;
            mem.mem_wr_en   <= wr_en_d;
            mem.mem_wr_addr <= wr_addr_d;
            mem.mem_wr_data <= wr_data_d;
            if (result_en) result <= c_flat;
            for (int unsigned k = 0; k < ELEMS; k++) begin
                if (cap_en && (cap_idx == CW'(k))) a_flat[k*DW +: DW] <= mem.mem_rd_data;
            end
        end
    end

    // Next-state and next-output logic; cnt is the index of the element being issued next.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        src_d     = src_q;
        dst_d     = dst_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        result_en = 1'b0;
        cap_en    = 1'b0;
        cap_idx   = cnt - CW'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    src_d     = src_base;
                    dst_d     = dst_base;
                    rd_en_d   = 1'b1;
                    rd_addr_d = src_base;
                end
            end
            LOAD: begin
                // Data returning now belongs to the read issued last cycle.
                cap_en = (cnt != '0);
                if (cnt == CW'(ELEMS)) begin
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if ((cnt + CW'(1)) != CW'(ELEMS)) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = src_q + AW'(cnt + CW'(1));
                    end
                end
            end
            COMPUTE: begin
                // Element 0 comes straight from c_flat while result is being captured.
                result_en = 1'b1;
                state_d   = STORE;
                cnt_d     = CW'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = dst_q;
                wr_data_d = elem_at(c_flat, '0);
            end
            STORE: begin
                if (cnt == CW'(ELEMS)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_q + AW'(cnt);
                    wr_data_d = elem_at(result, cnt);
                    cnt_d     = cnt + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_transpose_ctrl.sv
// Directed bench: cycle-level timing model of the transpose sequence plus literal spot checks.
module tb_matrix_transpose_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [7:0]   src_base = 8'h00;
    logic [7:0]   dst_base = 8'h00;
    logic         busy, done;
    logic [199:0] a_flat, c_flat;

    matrix_transpose_ctrl_if mem ();

    matrix_transpose_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .busy     (busy),
        .done     (done),
        .a_flat   (a_flat),
        .c_flat   (c_flat),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // External transpose datapath: C[r][c] = A[c][r].
    always_comb begin
        c_flat = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                c_flat[(r*5+c)*8 +: 8] = a_flat[(c*5+r)*8 +: 8];
    end

    // Memory: reads come from pre, writes land in wmem.
    logic [7:0] pre  [256];
    logic [7:0] wmem [256];
    always @(posedge clk) begin
        if (mem.mem_rd_en) mem.mem_rd_data <= pre[mem.mem_rd_addr];
        if (mem.mem_wr_en) wmem[mem.mem_wr_addr] <= mem.mem_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_flat(input string nm, input logic [199:0] act, input logic [199:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation is a fixed timeline relative to its accepting edge t0.
    int         e = 0;
    int         t0 = 0;
    bit         active = 1'b0;
    logic [7:0] ms = 8'h00, md = 8'h00;
    logic [7:0] snap [25];
    logic [7:0] ma   [25];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 1'b0;
            for (int k = 0; k < 25; k++) ma[k] = 8'h00;
        end else begin
            e++;
            if ((!active || (e - t0) >= 54) && start) begin
                active = 1'b1;
                t0 = e;
                ms = src_base;
                md = dst_base;
                for (int k = 0; k < 25; k++) snap[k] = pre[8'(src_base + 8'(k))];
            end
            if (active && (e + 1 - t0) >= 3 && (e + 1 - t0) <= 27)
                ma[e + 1 - t0 - 3] = snap[e + 1 - t0 - 3];
        end
    end

    // Compare process: every cycle, DUT outputs against the timeline model.
    always @(negedge clk) begin
        int           j, kk;
        logic         eb, ed, er, ew;
        logic [7:0]   ra, wa, wd;
        logic [199:0] ea;
        j  = active ? (e + 1 - t0) : 0;
        eb = (j >= 1 && j <= 53);
        ed = (j == 53);
        er = (j >= 1 && j <= 25);
        ew = (j >= 28 && j <= 52);
        kk = ew ? (j - 28) : 0;
        ra = er ? 8'(ms + 8'(j - 1)) : 8'h00;
        wa = ew ? 8'(md + 8'(kk)) : 8'h00;
        wd = ew ? snap[(kk % 5) * 5 + kk / 5] : 8'h00;
        for (int k = 0; k < 25; k++) ea[k*8 +: 8] = ma[k];
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("rd_en", 32'(mem.mem_rd_en), 32'(er));
        chk("rd_addr", 32'(mem.mem_rd_addr), 32'(ra));
        chk("wr_en", 32'(mem.mem_wr_en), 32'(ew));
        chk("wr_addr", 32'(mem.mem_wr_addr), 32'(wa));
        chk("wr_data", 32'(mem.mem_wr_data), 32'(wd));
        chk("rd_wr_excl", 32'(mem.mem_rd_en & mem.mem_wr_en), 32'(0));
        chk_flat("a_flat", a_flat, ea);
    end

    logic [7:0] rd_log [64];
    int         rd_n = 0;

    // mode 0: plain op; 1: start re-raised at cycle 10 and held to 54; 2: reset at cycle 15.
    task automatic run_op(input logic [7:0] s, input logic [7:0] d, input int mode, input int ncyc,
                          output int done_at, output int done_cnt, output int wr_cyc, output int busy54);
        done_at = 0; done_cnt = 0; wr_cyc = 0; busy54 = -1; rd_n = 0;
        @(posedge clk); #2;
        src_base = s; dst_base = d; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (mode == 1 && n == 10) start = 1'b1;
            if (mode == 1 && n == 55) start = 1'b0;
            if (mode == 2 && n == 15) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_rd_en", 32'(mem.mem_rd_en), 32'(0));
                chk("rst_wr_en", 32'(mem.mem_wr_en), 32'(0));
                chk_flat("rst_a_flat", a_flat, 200'd0);
            end
            if (mode == 2 && n == 18) #2 rst_n = 1'b1;
            if (mem.mem_rd_en && rd_n < 64) begin
                rd_log[rd_n] = mem.mem_rd_addr;
                rd_n++;
            end
            if (mem.mem_wr_en) wr_cyc++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (n == 54) busy54 = 32'(busy);
        end
    endtask

    initial begin
        int done_at, done_cnt, wr_cyc, busy54;
        for (int k = 0; k < 256; k++) pre[k] = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_rd_addr", 32'(mem.mem_rd_addr), 32'(0));
        chk_flat("reset_a_flat", a_flat, 200'd0);
        #1 rst_n = 1'b1;

        // Identity-indexed matrix at 0x00 -> 0x40.
        for (int k = 0; k < 25; k++) pre[k] = 8'(k);
        run_op(8'h00, 8'h40, 0, 60, done_at, done_cnt, wr_cyc, busy54);
        chk("t1_latency", 32'(done_at), 32'(53));
        chk("t1_done_cnt", 32'(done_cnt), 32'(1));
        chk("t1_wr_cycles", 32'(wr_cyc), 32'(25));
        chk("t1_dst1", 32'(wmem[8'h41]), 32'(5));
        chk("t1_dst5", 32'(wmem[8'h45]), 32'(1));
        chk("t1_dst24", 32'(wmem[8'h58]), 32'(24));
        chk("t1_a_hold", 32'(a_flat[24*8 +: 8]), 32'(24));

        // Source wraps past 0xFF.
        for (int k = 0; k < 25; k++) pre[8'(8'hF0 + 8'(k))] = 8'(k * 3 + 7);
        run_op(8'hF0, 8'h80, 0, 60, done_at, done_cnt, wr_cyc, busy54);
        chk("t2_latency", 32'(done_at), 32'(53));
        chk("t2_reads", 32'(rd_n), 32'(25));
        chk("t2_rd0", 32'(rd_log[0]), 32'(8'hF0));
        chk("t2_rd15", 32'(rd_log[15]), 32'(8'hFF));
        chk("t2_rd16", 32'(rd_log[16]), 32'(8'h00));
        chk("t2_rd24", 32'(rd_log[24]), 32'(8'h08));
        chk("t2_dst1", 32'(wmem[8'h81]), 32'(22));

        // start held across the op is not queued; accepted once IDLE returns.
        run_op(8'hF0, 8'h60, 1, 110, done_at, done_cnt, wr_cyc, busy54);
        chk("t3_first_done", 32'(done_at), 32'(53));
        chk("t3_busy54", 32'(busy54), 32'(0));
        chk("t3_done_cnt", 32'(done_cnt), 32'(2));

        // Reset mid-load aborts; a following op completes.
        for (int k = 0; k < 25; k++) pre[8'h30 + k] = 8'(8'h10 + k);
        run_op(8'h30, 8'h70, 2, 60, done_at, done_cnt, wr_cyc, busy54);
        chk("t4_abort_done", 32'(done_cnt), 32'(0));
        chk("t4_abort_wr", 32'(wr_cyc), 32'(0));
        run_op(8'h30, 8'h70, 0, 60, done_at, done_cnt, wr_cyc, busy54);
        chk("t4_latency", 32'(done_at), 32'(53));
        chk("t4_dst1", 32'(wmem[8'h71]), 32'(8'h15));

        // Diagonal-only matrix is its own transpose.
        for (int k = 0; k < 25; k++) pre[8'h20 + k] = (k % 6 == 0) ? 8'hAA : 8'h00;
        run_op(8'h20, 8'hA0, 0, 60, done_at, done_cnt, wr_cyc, busy54);
        chk("t5_wr_cycles", 32'(wr_cyc), 32'(25));
        for (int k = 0; k < 25; k++)
            chk("t5_diag", 32'(wmem[8'hA0 + k]), 32'(pre[8'h20 + k]));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
